pw_bit_cell: RTL and testbench
==============================

Name: pw_bit_cell

Overview:
- Pulse-width bit serializer: accepts data words on an AXI4-Stream slave and transmits each bit on the single-wire output `txd` as a fixed-length "bit cell".
- Each bit cell is high for a programmable time and low for the rest of the cell. The high time is `duty_hi` for a 1 and `duty_lo` for a 0.
- Sits between a DMA/stream source and an output pin, e.g. for LED-strip or one-wire style protocols.

Parameters:
- COUNTER_WIDTH, 32, width of the period/duty timing inputs and of the internal cycle counter.
- AXIS_DATA_WIDTH, 8, tdata width. Must be a multiple of 8.

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- aresetn  in  1  reset, synchronous, active-low.
- txd  out  1  serial pulse-width output, registered.
- s_axis_tdata  in  AXIS_DATA_WIDTH  word to transmit.
- s_axis_tstrb  in  AXIS_DATA_WIDTH/8  byte-lane enables; a lane whose bit is 0 is not transmitted.
- s_axis_tlast  in  1  end of frame; an idle gap follows this word.
- s_axis_tvalid  in  1  source has a word.
- s_axis_tready  out  1  block can accept a word.
- period  in  COUNTER_WIDTH  bit-cell length in aclk cycles.
- duty_hi  in  COUNTER_WIDTH  high cycles for a 1 bit.
- duty_lo  in  COUNTER_WIDTH  high cycles for a 0 bit.

Behaviour:
- Reset (aresetn=0 at a rising edge):
  - txd=0 and tready=0 the following cycle.
  - Counters and shift register are cleared; state goes to IDLE.
  - Applies mid-transmission too: the current word is dropped.
- States: IDLE, SEND, GAP.
- IDLE:
  - tready=1 and txd=0.
  - On tvalid&tready at an edge, the block captures tdata, tstrb, tlast, period, duty_hi and duty_lo, then enters SEND.
  - tready=0 from the next cycle. Timing inputs may change freely while a word is in flight.
- SEND:
  - Bits go out MSB first over the whole word: highest byte lane first, bit 7 first within each lane.
  - Lanes with strobe 0 are skipped and emit no cells.
  - The first cell starts the cycle after the handshake.
  - Within a cell the cycle counter c runs 0..P-1. txd=1 while c < D, else 0, where D is duty_hi for a 1 bit and duty_lo for a 0 bit.
  - P is the captured period; P=0 is treated as 1.
  - If D ≥ P, txd stays high for the whole cell. If D=0, txd stays low for the whole cell.
  - Cells are back to back with no dead cycles.
- After the last cell:
  - If the captured tlast=1, go to GAP.
  - Otherwise go to IDLE; tready=1 on the cycle after the last cell cycle.
- GAP: txd=0 for P cycles, then IDLE.
- A word with all strobes 0 emits no cells. It goes to GAP if tlast=1, otherwise straight to IDLE.
- Counter arithmetic is unsigned at COUNTER_WIDTH. The bit index counter is sized as clog2(AXIS_DATA_WIDTH)+1.
- tready is never asserted outside IDLE; there is no skid buffer.

Decomposition:
- Package pw_bit_pkg:
  - state enum {IDLE, SEND, GAP}.
  - Function effective_period(p), returning max(p,1).
- One sub-module, pw_bit_timer:
  - Inputs: start, bit value, P, duty_hi, duty_lo.
  - Outputs: registered level and a cell_done pulse.
  - pw_bit_cell holds the FSM, the capture registers, and the lane/bit sequencing.

Test Plan:
- Single byte, AXIS_DATA_WIDTH=8, COUNTER_WIDTH=8. tdata=0xCC, tstrb=1, tlast=1, period=100, duty_hi=75, duty_lo=25, tvalid held high from reset.
  - Handshake on the first edge after reset release.
  - txd pattern: H75/L25, H75/L25, H25/L75, H25/L75, then the same again; 800 cycles total.
  - Then 100 low gap cycles, then tready=1.
- Back-to-back words with tlast=0, 0xFF then 0x00, period=10, duty_hi=7, duty_lo=3.
  - 8 cells high 7 cycles each, then 8 cells high 3 cycles each.
  - No gap between the words; tready high exactly one cycle between them.
- Boundaries at period=4:
  - duty_hi=4 → a 1 bit is constant high for 4 cycles.
  - duty_lo=0 → a 0 bit is constant low.
  - period=0, duty=1 → each cell lasts 1 cycle.
- Strobe, AXIS_DATA_WIDTH=16, tdata=0xA55A.
  - tstrb=2'b01 → only 0x5A is sent: 8 cells, MSB first.
  - tstrb=0 with tlast=1 → no cells, only the gap.
- Reset mid-cell: drop aresetn during the 3rd bit.
  - txd=0 and tready=0 the next cycle.
  - After release, tready=1 and no residual cells.
- Parameter change mid-word: change period/duty_hi after the handshake.
  - The current word uses the captured values; the next word uses the new ones.

Source files
------------

// File: rtl/pw_bit_pkg.sv
// Shared types and helpers for the pulse-width bit serializer.
package pw_bit_pkg;

  localparam int unsigned MaxCounterWidth = 64;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StGap
  } state_e;

  // A zero-length cell would never terminate, so it is stretched to one cycle.
  function automatic logic [MaxCounterWidth-1:0] effective_period(
    input logic [MaxCounterWidth-1:0] p
  );
    return (p == '0) ? MaxCounterWidth'(1) : p;
  endfunction

endpackage

// File: rtl/pw_bit_timer.sv
// One bit cell: high for D cycles of a P-cycle cell, with a pulse on its last cycle.
module pw_bit_timer
  import pw_bit_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = 32
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     start_i,
  input  logic                     bit_i,
  input  logic                     gap_i,
  input  logic [COUNTER_WIDTH-1:0] period_i,
  input  logic [COUNTER_WIDTH-1:0] duty_hi_i,
  input  logic [COUNTER_WIDTH-1:0] duty_lo_i,
  output logic                     level_o,
  output logic                     cell_done_o
);

  logic [COUNTER_WIDTH-1:0] count_q;
  logic [COUNTER_WIDTH-1:0] p_q;
  logic [COUNTER_WIDTH-1:0] d_q;
  logic                     active_q;
  logic                     level_q;
  logic [COUNTER_WIDTH-1:0] d_start;
  logic [COUNTER_WIDTH-1:0] count_inc;

  // A gap is just a cell whose duty is forced to zero.
  always_comb begin
    d_start   = gap_i ? '0 : (bit_i ? duty_hi_i : duty_lo_i);
    count_inc = count_q + COUNTER_WIDTH'(1);
  end

  assign cell_done_o = active_q && (count_q == p_q - COUNTER_WIDTH'(1));
  assign level_o     = level_q;

  // level_q is loaded with the value for the cycle about to start, so it stays registered.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      count_q  <= '0;
      p_q      <= '0;
      d_q      <= '0;
      active_q <= 1'b0;
      level_q  <= 1'b0;
    end else if (start_i) begin
      active_q <= 1'b1;
      count_q  <= '0;
      p_q      <= COUNTER_WIDTH'(effective_period(MaxCounterWidth'(period_i)));
      d_q      <= d_start;
      level_q  <= (d_start != '0);
    end else if (cell_done_o) begin
      active_q <= 1'b0;
      count_q  <= '0;
      level_q  <= 1'b0;
    end else if (active_q) begin
      count_q  <= count_inc;
      level_q  <= (count_inc < d_q);
    end
  end

endmodule

// File: rtl/pw_bit_cell.sv
// AXI4-Stream to pulse-width serializer: FSM, capture registers and lane/bit sequencing.
module pw_bit_cell
  import pw_bit_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH   = 32,
  parameter int unsigned AXIS_DATA_WIDTH = 8
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  output logic                         txd,
  input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic                         s_axis_tlast,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic [COUNTER_WIDTH-1:0]     period,
  input  logic [COUNTER_WIDTH-1:0]     duty_hi,
  input  logic [COUNTER_WIDTH-1:0]     duty_lo
);

  localparam int unsigned NumLanes = AXIS_DATA_WIDTH / 8;
  localparam int unsigned IdxWidth = $clog2(AXIS_DATA_WIDTH) + 1;

  state_e                     state_q;
  logic                       tready_q;
  logic [AXIS_DATA_WIDTH-1:0] shift_q;
  logic [IdxWidth-1:0]        bits_left_q;
  logic                       last_q;
  logic [COUNTER_WIDTH-1:0]   period_q;
  logic [COUNTER_WIDTH-1:0]   duty_hi_q;
  logic [COUNTER_WIDTH-1:0]   duty_lo_q;

  logic                       handshake;
  logic [AXIS_DATA_WIDTH-1:0] packed_word;
  logic [IdxWidth-1:0]        packed_bits;
  int unsigned                lane_cnt;
  logic                       start;
  logic                       start_bit;
  logic                       start_gap;
  logic                       cell_done;
  logic                       level;
  logic [COUNTER_WIDTH-1:0]   t_period;
  logic [COUNTER_WIDTH-1:0]   t_duty_hi;
  logic [COUNTER_WIDTH-1:0]   t_duty_lo;

  assign handshake     = (state_q == StIdle) && tready_q && s_axis_tvalid;
  assign s_axis_tready = tready_q;
  assign txd           = level;

  // Squeeze enabled lanes together, highest lane first, left-aligned so bit W-1 goes out first.
  always_comb begin
    packed_word = '0;
    lane_cnt    = 0;
    for (int lane = NumLanes - 1; lane >= 0; lane--) begin
      if (s_axis_tstrb[lane]) begin
        packed_word = (packed_word << 8) | AXIS_DATA_WIDTH'(s_axis_tdata[8*lane +: 8]);
        lane_cnt    = lane_cnt + 1;
      end
    end
    packed_word = packed_word << (AXIS_DATA_WIDTH - 8 * lane_cnt);
    packed_bits = IdxWidth'(8 * lane_cnt);
  end

  // The first cell starts straight off the handshake, so timing comes from the live inputs then.
  always_comb begin
    start     = 1'b0;
    start_bit = 1'b0;
    start_gap = 1'b0;
    t_period  = period_q;
    t_duty_hi = duty_hi_q;
    t_duty_lo = duty_lo_q;
    if (handshake) begin
      t_period  = period;
      t_duty_hi = duty_hi;
      t_duty_lo = duty_lo;
      if (packed_bits != '0) begin
        start     = 1'b1;
        start_bit = packed_word[AXIS_DATA_WIDTH-1];
      end else if (s_axis_tlast) begin
        start     = 1'b1;
        start_gap = 1'b1;
      end
    end else if (state_q == StSend && cell_done) begin
      if (bits_left_q != '0) begin
        start     = 1'b1;
        start_bit = shift_q[AXIS_DATA_WIDTH-1];
      end else if (last_q) begin
        start     = 1'b1;
        start_gap = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= StIdle;
      tready_q    <= 1'b0;
      shift_q     <= '0;
      bits_left_q <= '0;
      last_q      <= 1'b0;
      period_q    <= '0;
      duty_hi_q   <= '0;
      duty_lo_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (handshake) begin
            tready_q    <= 1'b0;
            shift_q     <= packed_word << 1;
            bits_left_q <= (packed_bits == '0) ? '0 : packed_bits - IdxWidth'(1);
            last_q      <= s_axis_tlast;
            period_q    <= period;
            duty_hi_q   <= duty_hi;
            duty_lo_q   <= duty_lo;
            if (packed_bits != '0) begin
              state_q <= StSend;
            end else if (s_axis_tlast) begin
              state_q <= StGap;
            end
          end else begin
            tready_q <= 1'b1;
          end
        end
        StSend: begin
          if (cell_done) begin
            if (bits_left_q != '0) begin
              shift_q     <= shift_q << 1;
              bits_left_q <= bits_left_q - IdxWidth'(1);
            end else if (last_q) begin
              state_q <= StGap;
            end else begin
              state_q  <= StIdle;
              tready_q <= 1'b1;
            end
          end
        end
        StGap: begin
          if (cell_done) begin
            state_q  <= StIdle;
            tready_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= StIdle;
          tready_q <= 1'b0;
        end
      endcase
    end
  end

  pw_bit_timer #(
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_timer (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .start_i    (start),
    .bit_i      (start_bit),
    .gap_i      (start_gap),
    .period_i   (t_period),
    .duty_hi_i  (t_duty_hi),
    .duty_lo_i  (t_duty_lo),
    .level_o    (level),
    .cell_done_o(cell_done)
  );

endmodule

// File: tb/tb_pw_bit_cell.sv
// Randomized bench for pw_bit_cell against a per-cycle waveform model built from the bit-cell rules.
module tb_pw_bit_cell;

  logic        aclk;
  logic        aresetn;
  logic        txd;
  logic [15:0] s_axis_tdata;
  logic [1:0]  s_axis_tstrb;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [7:0]  period;
  logic [7:0]  duty_hi;
  logic [7:0]  duty_lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  strb;
    logic        last;
    logic [7:0]  p;
    logic [7:0]  dh;
    logic [7:0]  dl;
  } word_t;

  word_t words[$];
  bit    exp_txd[$];
  bit    exp_rdy[$];

  pw_bit_cell #(
    .COUNTER_WIDTH  (8),
    .AXIS_DATA_WIDTH(16)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .txd          (txd),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tstrb (s_axis_tstrb),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .period       (period),
    .duty_hi      (duty_hi),
    .duty_lo      (duty_lo)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic word_t mk(logic [15:0] data, logic [1:0] strb, logic last,
                               logic [7:0] p, logic [7:0] dh, logic [7:0] dl);
    word_t w;
    w.data = data; w.strb = strb; w.last = last; w.p = p; w.dh = dh; w.dl = dl;
    return w;
  endfunction

  // Expected (txd, tready) for every cycle after the handshake, through the first ready cycle.
  task automatic model_word(input word_t w);
    int pe = (w.p == 0) ? 1 : int'(w.p);
    int n  = 0;
    for (int lane = 1; lane >= 0; lane--) begin
      if (w.strb[lane]) begin
        for (int b = 7; b >= 0; b--) begin
          int d = w.data[lane*8+b] ? int'(w.dh) : int'(w.dl);
          for (int c = 0; c < pe; c++) begin
            exp_txd.push_back(c < d);
            exp_rdy.push_back(1'b0);
          end
          n++;
        end
      end
    end
    if (w.last) begin
      for (int c = 0; c < pe; c++) begin
        exp_txd.push_back(1'b0);
        exp_rdy.push_back(1'b0);
      end
    end
    if (n == 0 && !w.last) begin
      exp_txd.push_back(1'b0);
      exp_rdy.push_back(1'b0);
    end
    exp_txd.push_back(1'b0);
    exp_rdy.push_back(1'b1);
  endtask

  task automatic drive_word(input word_t w);
    s_axis_tdata  = w.data;
    s_axis_tstrb  = w.strb;
    s_axis_tlast  = w.last;
    period        = w.p;
    duty_hi       = w.dh;
    duty_lo       = w.dl;
    s_axis_tvalid = 1'b1;
  endtask

  // Garbage on every input while a word is in flight; the captured copy must be used.
  task automatic scramble();
    s_axis_tdata = 16'($urandom);
    s_axis_tstrb = 2'($urandom);
    s_axis_tlast = 1'($urandom);
    period       = 8'($urandom);
    duty_hi      = 8'($urandom);
    duty_lo      = 8'($urandom);
  endtask

  task automatic run_words();
    bit hs = 1'b0;
    int idx;
    int cyc = 0;
    bit e_txd;
    bit e_rdy;
    exp_txd.delete();
    exp_rdy.delete();
    foreach (words[i]) model_word(words[i]);
    for (int i = 0; i < 20 && !hs; i++) begin
      @(negedge aclk);
      if (s_axis_tready === 1'b1) hs = 1'b1;
    end
    checks++;
    if (!hs) begin
      errors++;
      $display("FAIL ready_wait: tready=%b required 1", s_axis_tready);
      words.delete();
      return;
    end
    drive_word(words[0]);
    idx = 1;
    @(posedge aclk);
    #1 scramble();
    while (exp_txd.size() > 0) begin
      @(negedge aclk);
      e_txd = exp_txd.pop_front();
      e_rdy = exp_rdy.pop_front();
      checks++;
      if (txd !== e_txd || s_axis_tready !== e_rdy) begin
        errors++;
        $display("FAIL stream cycle %0d: txd=%b tready=%b required txd=%b tready=%b",
                 cyc, txd, s_axis_tready, e_txd, e_rdy);
      end
      cyc++;
      if (e_rdy) begin
        if (idx < words.size()) begin
          drive_word(words[idx]);
          idx++;
          @(posedge aclk);
          #1 scramble();
        end else begin
          s_axis_tvalid = 1'b0;
        end
      end
    end
    words.delete();
  endtask

  task automatic test_reset();
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tstrb  = '0;
    s_axis_tlast  = 1'b0;
    period        = '0;
    duty_hi       = '0;
    duty_lo       = '0;
    repeat (3) @(negedge aclk);
    checks++;
    if (txd !== 1'b0) begin
      errors++;
      $display("FAIL reset_txd: txd=%b required 0", txd);
    end
    checks++;
    if (s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_tready: tready=%b required 0", s_axis_tready);
    end
    aresetn = 1'b1;
    @(negedge aclk);
    checks++;
    if (s_axis_tready !== 1'b1 || txd !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: tready=%b txd=%b required tready=1 txd=0",
               s_axis_tready, txd);
    end
  endtask

  task automatic test_single_byte();
    words.push_back(mk(16'h00CC, 2'b01, 1'b1, 8'd100, 8'd75, 8'd25));
    run_words();
  endtask

  task automatic test_back_to_back();
    words.push_back(mk(16'h00FF, 2'b01, 1'b0, 8'd10, 8'd7, 8'd3));
    words.push_back(mk(16'h0000, 2'b01, 1'b0, 8'd10, 8'd7, 8'd3));
    run_words();
  endtask

  task automatic test_boundaries();
    words.push_back(mk(16'h00A5, 2'b01, 1'b0, 8'd4, 8'd4, 8'd0));
    words.push_back(mk(16'h5A00, 2'b10, 1'b1, 8'd0, 8'd1, 8'd1));
    words.push_back(mk(16'h00C3, 2'b01, 1'b0, 8'd0, 8'd1, 8'd0));
    run_words();
  endtask

  task automatic test_strobe();
    words.push_back(mk(16'hA55A, 2'b01, 1'b0, 8'd3, 8'd2, 8'd1));
    words.push_back(mk(16'hA55A, 2'b00, 1'b1, 8'd5, 8'd2, 8'd1));
    words.push_back(mk(16'hA55A, 2'b00, 1'b0, 8'd5, 8'd2, 8'd1));
    words.push_back(mk(16'hA55A, 2'b11, 1'b0, 8'd2, 8'd1, 8'd0));
    run_words();
  endtask

  task automatic test_param_change();
    words.push_back(mk(16'h00F0, 2'b01, 1'b0, 8'd6, 8'd5, 8'd1));
    words.push_back(mk(16'h000F, 2'b01, 1'b1, 8'd9, 8'd2, 8'd8));
    run_words();
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      words.push_back(mk(16'($urandom), 2'($urandom), 1'($urandom),
                         8'($urandom_range(0, 9)), 8'($urandom_range(0, 12)),
                         8'($urandom_range(0, 12))));
    end
    run_words();
  endtask

  task automatic test_reset_mid_cell();
    bit hs    = 1'b0;
    bit quiet = 1'b1;
    for (int i = 0; i < 20 && !hs; i++) begin
      @(negedge aclk);
      if (s_axis_tready === 1'b1) hs = 1'b1;
    end
    drive_word(mk(16'h00FF, 2'b01, 1'b0, 8'd10, 8'd7, 8'd3));
    @(posedge aclk);
    #1 s_axis_tvalid = 1'b0;
    // Cycle 23 is c=3 of the third cell.
    repeat (24) @(negedge aclk);
    checks++;
    if (txd !== 1'b1) begin
      errors++;
      $display("FAIL mid_cell_level: txd=%b required 1", txd);
    end
    aresetn = 1'b0;
    @(negedge aclk);
    checks++;
    if (txd !== 1'b0 || s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL mid_cell_reset: txd=%b tready=%b required txd=0 tready=0",
               txd, s_axis_tready);
    end
    aresetn = 1'b1;
    @(negedge aclk);
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL mid_cell_release: tready=%b required 1", s_axis_tready);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge aclk);
      if (txd !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL mid_cell_residual: txd pulsed=1 required 0");
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_boundaries();
    test_strobe();
    test_param_change();
    test_random();
    test_reset_mid_cell();
    test_single_byte();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
